fpu_scheduler: RTL and testbench
================================

# fpu_scheduler

Issue and writeback scheduler for the four FPU execution units (add/sub, multiply, divide, square root) of the pipelined RV32IMF core. It sits between the execute stage and the FPU units. It accepts one FP operation per cycle, pulses the start input of the target unit, and tracks each unit's busy/holding state. Variable-latency results return to a single FP register-file writeback port through a round-robin arbiter.

## Interface
- `RD_W`, default 5: FP destination register index width.
- `DATA_W`, default 32: result width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `issue_valid`  in  1  execute stage presents an FP op.
- `issue_op`  in  3  op code: 0 add, 1 sub, 2 mul, 3 div, 4 sqrt; 5-7 illegal.
- `issue_rd`  in  RD_W  destination FP register.
- `issue_ready`  out  1  op accepted at this edge when high together with `issue_valid`.
- `fpu_stall`  out  1  `issue_valid && !issue_ready`.
- `unit_start`  out  4  one-hot start pulse: bit0 addsub, bit1 mul, bit2 div, bit3 sqrt.
- `unit_sub`  out  1  add/sub select; equals `issue_op==1`.
- `unit_done`  in  4  one-cycle result-valid pulse per unit.
- `unit_result`  in  4*DATA_W  flattened results; unit i occupies bits [i*DATA_W +: DATA_W].
- `busy`  out  4  per-unit state is not IDLE.
- `wb_valid`  out  1  writeback register holds a result.
- `wb_rd`  out  RD_W  writeback destination.
- `wb_data`  out  DATA_W  writeback value.
- `wb_ready`  in  1  register file consumes the writeback this edge.
- `illegal_op`  out  1  registered one-cycle pulse after an illegal op is accepted.

## Operation
- Each unit has its own FSM with states IDLE, BUSY and HOLD, plus a stored rd and a result-holding register.
- Issue and start:
  - `issue_ready` is high when the target unit is IDLE; see Configuration for the additional WAW condition.
  - On accept, `unit_start` (combinational) pulses the target bit, the unit's rd is stored, and the unit goes IDLE→BUSY.
  - Operands travel directly from the pipeline to the units and do not pass through this block.
- Completion:
  - `unit_done[i]` seen in BUSY: capture that unit's `unit_result` slice and go BUSY→HOLD.
  - `unit_done[i]` seen in IDLE or HOLD is ignored.
- Writeback register:
  - It is free when `!wb_valid || wb_ready`.
  - When it is free and at least one unit is in HOLD, the arbiter grants one HOLD unit, loads its rd and result into `wb_*`, sets `wb_valid`, and moves the unit HOLD→IDLE.
  - If the register frees and no unit is in HOLD, `wb_valid` clears; `wb_rd` and `wb_data` keep their values.
- Arbitration:
  - Round-robin pointer `rr` (2 bits); search order is rr, rr+1, … modulo 4.
  - After a grant, rr becomes granted index + 1.
- Illegal ops (5-7): `issue_ready=1`, the op is dropped, no start pulse, and `illegal_op` pulses the next cycle.

## Timing
- Issue: accept at edge E; `busy[i]` is high after E. Units return `unit_done` no earlier than E+1.
- Done→writeback: done sampled at edge D puts the unit in HOLD after D. If the register is free at D+1, `wb_valid` is high after D+1 and the unit is IDLE after D+1.
- Minimum done→`wb_valid` latency is 2 cycles.
- Re-issue: a unit can accept a new op in the cycle after it leaves HOLD.
- Simultaneous done, grant and accept across different units are all honoured at the same edge.
- Reset values: all units IDLE; rr=0; `wb_valid`, `wb_rd`, `wb_data`, `busy` and `illegal_op` are 0.
- Combinational outputs (`unit_start`, `issue_ready`) are 0 during reset.
- Reset mid-operation discards all outstanding ops. Later `unit_done` pulses from units that were running are ignored because those units are IDLE.

## Configuration
- `FPU_WAW_CHECK_EN` defined:
  - `issue_ready` additionally requires that `issue_rd` matches no stored rd of a BUSY or HOLD unit, and does not match `wb_rd` while `wb_valid` is high.
  - This guarantees in-order writes to the same FP register.
- Not defined: no rd comparison is made, and writebacks to the same register occur in arbitration order.

## Test plan
- Reset asserted mid-BUSY, then released, then a `unit_done` pulse → all outputs 0, `busy=0`, no writeback.
- mul rd=3 accepted; `unit_done[1]` 3 cycles later with result 0x40400000 → `wb_valid` 2 cycles after done, `wb_rd=3`, `wb_data=0x40400000`; `busy[1]` low after the load edge.
- div rd=4 busy; second div issued → `issue_ready=0`, `fpu_stall=1` until div returns to IDLE. An add issued meanwhile is accepted.
- addsub and sqrt done in the same cycle, rr=0, `wb_ready=0` for 3 cycles → addsub result held stable in `wb_*`; sqrt written back after the first `wb_ready` edge; rr ends at 0.
- div rd=7 busy, add rd=7 issued → stalled with `FPU_WAW_CHECK_EN`; accepted the same cycle without it.
- op=6 issued → accepted, `unit_start=0`, `illegal_op` high for exactly one cycle.

Source files
------------

// File: rtl/fpu_scheduler.sv
// fpu_scheduler: issue/writeback scheduler for the four FPU units
// (bit0 add/sub, bit1 mul, bit2 div, bit3 sqrt). Each unit has an
// IDLE/BUSY/HOLD tracker with a stored rd and result. Results in HOLD
// are funnelled through a round-robin arbiter into one writeback register.
// Optional feature: define FPU_WAW_CHECK_EN to stall issue on rd conflicts.
module fpu_scheduler #(
    parameter int RD_W   = 5,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_valid,
    input  logic [2:0]          issue_op,
    input  logic [RD_W-1:0]     issue_rd,
    output logic                issue_ready,
    output logic                fpu_stall,
    output logic [3:0]          unit_start,
    output logic                unit_sub,
    input  logic [3:0]          unit_done,
    input  logic [4*DATA_W-1:0] unit_result,
    output logic [3:0]          busy,
    output logic                wb_valid,
    output logic [RD_W-1:0]     wb_rd,
    output logic [DATA_W-1:0]   wb_data,
    input  logic                wb_ready,
    output logic                illegal_op
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } ustate_t;

    ustate_t           st   [4];
    logic [RD_W-1:0]   urd  [4];
    logic [DATA_W-1:0] ures [4];
    logic [1:0]        rr;

    logic       legal;
    logic [1:0] tgt;
    logic       waw_hit;
    logic [3:0] hold;
    logic       wb_free;
    logic       gnt_valid;
    logic [1:0] gnt_idx;
    logic [1:0] probe;

    // Decode the op code into a target unit and legality.
    always_comb begin
        legal = 1'b1;
        tgt   = 2'd0;
        case (issue_op)
            3'd0, 3'd1: tgt = 2'd0;
            3'd2:       tgt = 2'd1;
            3'd3:       tgt = 2'd2;
            3'd4:       tgt = 2'd3;
            default:    legal = 1'b0;
        endcase
    end

`ifdef FPU_WAW_CHECK_EN
    // Destination conflict against any outstanding or pending-writeback result.
    always_comb begin
        waw_hit = wb_valid && (wb_rd == issue_rd);
        for (int unsigned i = 0; i < 4; i++) begin
            if (st[i] != IDLE && urd[i] == issue_rd)
                waw_hit = 1'b1;
        end
    end
`else
    assign waw_hit = 1'b0;
`endif

    // Per-unit status vectors.
    always_comb begin
        busy = '0;
        hold = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            busy[i] = (st[i] != IDLE);
            hold[i] = (st[i] == HOLD);
        end
    end

    // Issue handshake and start pulse; held low while in reset.
    always_comb begin
        issue_ready = 1'b0;
        unit_start  = '0;
        if (!rst) begin
            issue_ready = legal ? ((st[tgt] == IDLE) && !waw_hit) : 1'b1;
            if (issue_valid && issue_ready && legal)
                unit_start = 4'b0001 << tgt;
        end
    end

    assign fpu_stall = issue_valid && !issue_ready;
    assign unit_sub  = (issue_op == 3'd1);
    assign wb_free   = !wb_valid || wb_ready;

    // Round-robin search over HOLD units starting at rr.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = 2'd0;
        probe     = 2'd0;
        for (int unsigned k = 0; k < 4; k++) begin
            probe = rr + 2'(k);
            if (!gnt_valid && hold[probe]) begin
                gnt_valid = 1'b1;
                gnt_idx   = probe;
            end
        end
    end

    // Unit trackers, writeback register, arbiter pointer and illegal pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 4; i++) begin
                st[i]   <= IDLE;
                urd[i]  <= '0;
                ures[i] <= '0;
            end
            rr         <= 2'd0;
            wb_valid   <= 1'b0;
            wb_rd      <= '0;
            wb_data    <= '0;
            illegal_op <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                case (st[i])
                    IDLE: if (unit_start[i]) begin
                        st[i]  <= BUSY;
                        urd[i] <= issue_rd;
                    end
                    BUSY: if (unit_done[i]) begin
                        st[i]   <= HOLD;
                        ures[i] <= unit_result[i*DATA_W +: DATA_W];
                    end
                    HOLD: if (wb_free && gnt_valid && gnt_idx == 2'(i))
                        st[i] <= IDLE;
                    default: st[i] <= IDLE;
                endcase
            end
            if (wb_free) begin
                if (gnt_valid) begin
                    wb_valid <= 1'b1;
                    wb_rd    <= urd[gnt_idx];
                    wb_data  <= ures[gnt_idx];
                    rr       <= gnt_idx + 2'd1;
                end else begin
                    wb_valid <= 1'b0;
                end
            end
            illegal_op <= issue_valid && !legal;
        end
    end

endmodule

// File: tb/tb_fpu_scheduler.sv
// Directed self-checking bench for fpu_scheduler.
module tb_fpu_scheduler;
    localparam int RD_W   = 5;
    localparam int DATA_W = 32;

    logic                clk = 1'b0;
    logic                rst;
    logic                issue_valid;
    logic [2:0]          issue_op;
    logic [RD_W-1:0]     issue_rd;
    logic                issue_ready;
    logic                fpu_stall;
    logic [3:0]          unit_start;
    logic                unit_sub;
    logic [3:0]          unit_done;
    logic [4*DATA_W-1:0] unit_result;
    logic [3:0]          busy;
    logic                wb_valid;
    logic [RD_W-1:0]     wb_rd;
    logic [DATA_W-1:0]   wb_data;
    logic                wb_ready;
    logic                illegal_op;

    int tests = 0;
    int fails = 0;

    fpu_scheduler #(.RD_W(RD_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_op(issue_op), .issue_rd(issue_rd),
        .issue_ready(issue_ready), .fpu_stall(fpu_stall),
        .unit_start(unit_start), .unit_sub(unit_sub),
        .unit_done(unit_done), .unit_result(unit_result),
        .busy(busy), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_ready(wb_ready), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        issue_valid = 1'b0; issue_op = '0; issue_rd = '0;
        unit_done = '0; unit_result = '0; wb_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        step();
    endtask

    task automatic issue(input logic [2:0] op, input logic [RD_W-1:0] rd);
        issue_valid = 1'b1; issue_op = op; issue_rd = rd;
        step();
        issue_valid = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        tests++; if (busy !== 4'b0000 || wb_valid !== 1'b0 || illegal_op !== 1'b0) begin
            fails++; $display("FAIL reset_state busy=%b wb_valid=%b illegal=%b expected 0000/0/0", busy, wb_valid, illegal_op); end
        issue(3'd2, 5'd2);
        tests++; if (busy !== 4'b0010) begin fails++; $display("FAIL reset_pre_busy busy=%b expected 0010", busy); end
        rst = 1'b1; issue_valid = 1'b1; issue_op = 3'd0; issue_rd = 5'd1;
        #1;
        tests++; if (issue_ready !== 1'b0 || unit_start !== 4'b0000 || busy !== 4'b0000) begin
            fails++; $display("FAIL reset_comb ready=%b start=%b busy=%b expected 0/0000/0000", issue_ready, unit_start, busy); end
        step();
        rst = 1'b0; issue_valid = 1'b0;
        step();
        unit_done = 4'b0010; unit_result[63:32] = 32'hDEADBEEF;
        step();
        unit_done = '0;
        step(); step();
        tests++; if (busy !== 4'b0000 || wb_valid !== 1'b0 || wb_rd !== 5'd0 || wb_data !== 32'd0) begin
            fails++; $display("FAIL reset_late_done busy=%b wb_valid=%b wb_rd=%0d wb_data=%h expected all zero", busy, wb_valid, wb_rd, wb_data); end
    endtask

    task automatic test_mul();
        apply_reset();
        issue_valid = 1'b1; issue_op = 3'd2; issue_rd = 5'd3;
        #1;
        tests++; if (issue_ready !== 1'b1 || unit_start !== 4'b0010 || unit_sub !== 1'b0) begin
            fails++; $display("FAIL mul_start ready=%b start=%b sub=%b expected 1/0010/0", issue_ready, unit_start, unit_sub); end
        step();
        issue_valid = 1'b0;
        tests++; if (busy !== 4'b0010) begin fails++; $display("FAIL mul_busy busy=%b expected 0010", busy); end
        step(); step();
        unit_done = 4'b0010; unit_result[63:32] = 32'h40400000;
        step();
        unit_done = '0;
        tests++; if (wb_valid !== 1'b0 || busy !== 4'b0010) begin
            fails++; $display("FAIL mul_hold wb_valid=%b busy=%b expected 0/0010", wb_valid, busy); end
        step();
        tests++; if (wb_valid !== 1'b1 || wb_rd !== 5'd3 || wb_data !== 32'h40400000 || busy !== 4'b0000) begin
            fails++; $display("FAIL mul_wb wb_valid=%b rd=%0d data=%h busy=%b expected 1/3/40400000/0000", wb_valid, wb_rd, wb_data, busy); end
        wb_ready = 1'b1;
        step();
        tests++; if (wb_valid !== 1'b0 || wb_data !== 32'h40400000) begin
            fails++; $display("FAIL mul_consume wb_valid=%b data=%h expected 0/40400000", wb_valid, wb_data); end
    endtask

    task automatic test_div_stall();
        apply_reset();
        wb_ready = 1'b1;
        issue(3'd3, 5'd4);
        issue_valid = 1'b1; issue_op = 3'd3; issue_rd = 5'd5;
        #1;
        tests++; if (issue_ready !== 1'b0 || fpu_stall !== 1'b1 || unit_start !== 4'b0000) begin
            fails++; $display("FAIL div_stall ready=%b stall=%b start=%b expected 0/1/0000", issue_ready, fpu_stall, unit_start); end
        issue_op = 3'd1; issue_rd = 5'd9;
        #1;
        tests++; if (issue_ready !== 1'b1 || unit_start !== 4'b0001 || unit_sub !== 1'b1) begin
            fails++; $display("FAIL div_add_accept ready=%b start=%b sub=%b expected 1/0001/1", issue_ready, unit_start, unit_sub); end
        step();
        issue_op = 3'd3; issue_rd = 5'd5;
        unit_done = 4'b0100; unit_result[95:64] = 32'h3F800000;
        step();
        unit_done = '0;
        tests++; if (fpu_stall !== 1'b1 || busy !== 4'b0101) begin
            fails++; $display("FAIL div_hold_stall stall=%b busy=%b expected 1/0101", fpu_stall, busy); end
        step();
        tests++; if (wb_valid !== 1'b1 || wb_rd !== 5'd4 || wb_data !== 32'h3F800000 || issue_ready !== 1'b1 || unit_start !== 4'b0100) begin
            fails++; $display("FAIL div_reissue wb_valid=%b rd=%0d data=%h ready=%b start=%b expected 1/4/3f800000/1/0100", wb_valid, wb_rd, wb_data, issue_ready, unit_start); end
        step();
        issue_valid = 1'b0;
        tests++; if (busy !== 4'b0101) begin fails++; $display("FAIL div_rebusy busy=%b expected 0101", busy); end
    endtask

    task automatic test_same_done();
        apply_reset();
        issue(3'd0, 5'd1);
        issue(3'd4, 5'd2);
        unit_done = 4'b1001;
        unit_result[31:0] = 32'h11111111; unit_result[127:96] = 32'h44444444;
        step();
        unit_done = '0;
        step();
        tests++; if (wb_valid !== 1'b1 || wb_rd !== 5'd1 || wb_data !== 32'h11111111 || busy !== 4'b1000) begin
            fails++; $display("FAIL same_first wb_valid=%b rd=%0d data=%h busy=%b expected 1/1/11111111/1000", wb_valid, wb_rd, wb_data, busy); end
        step(); step();
        tests++; if (wb_valid !== 1'b1 || wb_rd !== 5'd1 || wb_data !== 32'h11111111 || busy !== 4'b1000) begin
            fails++; $display("FAIL same_stable wb_valid=%b rd=%0d data=%h busy=%b expected 1/1/11111111/1000", wb_valid, wb_rd, wb_data, busy); end
        wb_ready = 1'b1;
        step();
        tests++; if (wb_valid !== 1'b1 || wb_rd !== 5'd2 || wb_data !== 32'h44444444 || busy !== 4'b0000) begin
            fails++; $display("FAIL same_second wb_valid=%b rd=%0d data=%h busy=%b expected 1/2/44444444/0000", wb_valid, wb_rd, wb_data, busy); end
        // rr should be back at 0: with units 0 and 1 both holding, unit 0 wins.
        issue(3'd0, 5'd5);
        issue(3'd2, 5'd6);
        unit_done = 4'b0011;
        unit_result[31:0] = 32'hA; unit_result[63:32] = 32'hB;
        step();
        unit_done = '0;
        step();
        tests++; if (wb_valid !== 1'b1 || wb_rd !== 5'd5 || wb_data !== 32'hA) begin
            fails++; $display("FAIL rr_order rd=%0d data=%h expected 5/0000000a", wb_rd, wb_data); end
        step();
        tests++; if (wb_valid !== 1'b1 || wb_rd !== 5'd6 || wb_data !== 32'hB) begin
            fails++; $display("FAIL rr_next rd=%0d data=%h expected 6/0000000b", wb_rd, wb_data); end
    endtask

    task automatic test_waw();
        apply_reset();
        issue(3'd3, 5'd7);
        issue_valid = 1'b1; issue_op = 3'd0; issue_rd = 5'd7;
        #1;
`ifdef FPU_WAW_CHECK_EN
        tests++; if (issue_ready !== 1'b0 || fpu_stall !== 1'b1 || unit_start !== 4'b0000) begin
            fails++; $display("FAIL waw ready=%b stall=%b start=%b expected 0/1/0000", issue_ready, fpu_stall, unit_start); end
`else
        tests++; if (issue_ready !== 1'b1 || fpu_stall !== 1'b0 || unit_start !== 4'b0001) begin
            fails++; $display("FAIL waw ready=%b stall=%b start=%b expected 1/0/0001", issue_ready, fpu_stall, unit_start); end
`endif
        step();
        issue_valid = 1'b0;
    endtask

    task automatic test_illegal();
        apply_reset();
        issue_valid = 1'b1; issue_op = 3'd6; issue_rd = 5'd8;
        #1;
        tests++; if (issue_ready !== 1'b1 || fpu_stall !== 1'b0 || unit_start !== 4'b0000) begin
            fails++; $display("FAIL illegal_accept ready=%b stall=%b start=%b expected 1/0/0000", issue_ready, fpu_stall, unit_start); end
        step();
        issue_valid = 1'b0;
        tests++; if (illegal_op !== 1'b1 || busy !== 4'b0000) begin
            fails++; $display("FAIL illegal_pulse illegal=%b busy=%b expected 1/0000", illegal_op, busy); end
        step();
        tests++; if (illegal_op !== 1'b0) begin fails++; $display("FAIL illegal_clear illegal=%b expected 0", illegal_op); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div_stall();
        test_same_done();
        test_waw();
        test_illegal();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
